// File: rtl/match_sequencer_if.sv
// Match sequencer bus: game-side inputs (frame pulse, button, scores, updater state) and the
// sequencer's registered control/status outputs.
//   frame_tick  one-clk pulse per vsync rising edge
//   btn         OR of all controller buttons, asynchronous level
//   p1_score    player 1 score from the game state updater
//   p2_score    player 2 score from the game state updater
//   play_state  updater state: 0 RESET, 1 PLAY_NEXT, 2 PLAY
//   upd_rst     reset request to the updater
//   upd_start   start request to the updater
//   phase       0 IDLE, 1 SERVE, 2 RALLY, 3 OVER
//   countdown   serve digit 3/2/1, else 0
//   winner      0 none, 1 player 1, 2 player 2, 3 draw
// master drives the game-side inputs; slave is the sequencer.
interface match_sequencer_if;
  logic       frame_tick;
  logic       btn;
  logic [7:0] p1_score;
  logic [7:0] p2_score;
  logic [1:0] play_state;
  logic       upd_rst;
  logic       upd_start;
  logic [2:0] phase;
  logic [1:0] countdown;
  logic [1:0] winner;

  modport master (
    output frame_tick, btn, p1_score, p2_score, play_state,
    input  upd_rst, upd_start, phase, countdown, winner
  );

  modport slave (
    input  frame_tick, btn, p1_score, p2_score, play_state,
    output upd_rst, upd_start, phase, countdown, winner
  );
endinterface

// File: rtl/match_sequencer.sv
// Match sequencer: walks a match through IDLE -> SERVE (3-2-1 countdown) -> RALLY -> OVER,
// issuing reset/start requests to the game state updater and reporting the winner.
// Ports:
//   clk   system clock, all logic on posedge
//   rst   synchronous, active-high reset
//   bus   match_sequencer_if.slave (see interface file for signal list)
// All outputs are registered; btn only reaches the logic through a 2-flop synchronizer.
module match_sequencer #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned OVER_FRAMES  = 300
) (
  input logic              clk,
  input logic              rst,
  match_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StRally = 3'd2,
    StOver  = 3'd3
  } phase_e;

  localparam logic [8:0] ServeLast = 9'(SERVE_FRAMES - 1);
  localparam logic [8:0] OverLast  = 9'(OVER_FRAMES - 1);
  localparam logic [7:0] WinScore  = 8'(WIN_SCORE);

  phase_e     state_q;
  logic       upd_rst_q;
  logic       start_q;
  logic [1:0] countdown_q;
  logic [1:0] winner_q;
  logic [8:0] frame_cnt_q;
  logic [7:0] p1_last_q;
  logic [7:0] p2_last_q;
  logic       btn_s1_q;
  logic       btn_s2_q;
  logic       btn_s3_q;

  logic btn_edge;
  logic score_event;
  logic p1_wins;
  logic p2_wins;

  // btn_s3_q only remembers the previous synchronized level for edge detection.
  assign btn_edge    = btn_s2_q & ~btn_s3_q;
  assign score_event = (bus.p1_score != p1_last_q) || (bus.p2_score != p2_last_q);
  assign p1_wins     = bus.p1_score >= WinScore;
  assign p2_wins     = bus.p2_score >= WinScore;

  always_ff @(posedge clk) begin
    btn_s1_q  <= bus.btn;
    btn_s2_q  <= btn_s1_q;
    btn_s3_q  <= btn_s2_q;
    p1_last_q <= bus.p1_score;
    p2_last_q <= bus.p2_score;

    if (rst) begin
      state_q     <= StIdle;
      upd_rst_q   <= 1'b1;
      start_q     <= 1'b0;
      countdown_q <= 2'd0;
      winner_q    <= 2'd0;
      frame_cnt_q <= 9'd0;
      btn_s1_q    <= 1'b0;
      btn_s2_q    <= 1'b0;
      btn_s3_q    <= 1'b0;
    end else begin
      // A strobe ends after the cycle that carries the first frame_tick seen while high,
      // so the updater samples start=1 on exactly one vsync. Later assignments in the
      // case below (a new trigger) take precedence.
      if (start_q && bus.frame_tick) begin
        start_q <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          upd_rst_q   <= 1'b1;
          countdown_q <= 2'd0;
          if (btn_edge) begin
            start_q     <= 1'b1;
            countdown_q <= 2'd3;
            frame_cnt_q <= 9'd0;
            upd_rst_q   <= 1'b0;
            state_q     <= StServe;
          end
        end

        StServe: begin
          upd_rst_q <= 1'b0;
          if (bus.frame_tick) begin
            if (frame_cnt_q == ServeLast) begin
              frame_cnt_q <= 9'd0;
              if (countdown_q == 2'd1) begin
                countdown_q <= 2'd0;
                start_q     <= 1'b1;
                state_q     <= StRally;
              end else begin
                countdown_q <= countdown_q - 2'd1;
              end
            end else begin
              frame_cnt_q <= frame_cnt_q + 9'd1;
            end
          end
        end

        StRally: begin
          if (score_event) begin
            frame_cnt_q <= 9'd0;
            if (p1_wins || p2_wins) begin
              winner_q <= {p2_wins, p1_wins};
              state_q  <= StOver;
            end else begin
              // Updater already sits in PLAY_NEXT; only the end-of-countdown strobe is due.
              countdown_q <= 2'd3;
              state_q     <= StServe;
            end
          end else if (bus.play_state == 2'd0) begin
            start_q   <= 1'b0;
            upd_rst_q <= 1'b1;
            state_q   <= StIdle;
          end
        end

        StOver: begin
          if (bus.frame_tick) begin
            if (frame_cnt_q == OverLast) begin
              frame_cnt_q <= 9'd0;
              winner_q    <= 2'd0;
              upd_rst_q   <= 1'b1;
              state_q     <= StIdle;
            end else begin
              frame_cnt_q <= frame_cnt_q + 9'd1;
            end
          end
        end

        default: begin
          upd_rst_q <= 1'b1;
          start_q   <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  assign bus.upd_rst   = upd_rst_q;
  assign bus.upd_start = start_q;
  assign bus.phase     = state_q;
  assign bus.countdown = countdown_q;
  assign bus.winner    = winner_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Self-checking bench for match_sequencer: a frame/phase-level model checked against the DUT
// on every cycle, plus directed scenarios with literal expectations.
module tb_match_sequencer;
  localparam int WinScore    = 7;
  localparam int ServeFrames = 4;
  localparam int OverFrames  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  match_sequencer_if bus();

  match_sequencer #(
    .WIN_SCORE   (WinScore),
    .SERVE_FRAMES(ServeFrames),
    .OVER_FRAMES (OverFrames)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int passes = 0;
  int start_samples = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- Behavioural model ----------------
  // Phase plus "ticks seen since entering the phase"; the countdown digit is derived from the
  // tick total rather than kept as a separate down-counter.
  int m_phase = 0;
  int m_ticks = 0;
  int m_winner = 0;
  bit m_start = 0;
  bit m_valid = 0;
  bit m_b1 = 0, m_b2 = 0, m_b3 = 0;
  int m_p1_last = 0, m_p2_last = 0;

  always @(posedge clk) begin
    automatic bit edge_seen = m_b2 && !m_b3;
    automatic bit ev = (int'(bus.p1_score) != m_p1_last) || (int'(bus.p2_score) != m_p2_last);
    automatic bit q1 = int'(bus.p1_score) >= WinScore;
    automatic bit q2 = int'(bus.p2_score) >= WinScore;
    automatic int nphase = m_phase;
    automatic int nticks = m_ticks;
    automatic int nwin = m_winner;
    automatic bit nstart = m_start;
    m_p1_last <= int'(bus.p1_score);
    m_p2_last <= int'(bus.p2_score);
    if (rst) begin
      m_b1 <= 0; m_b2 <= 0; m_b3 <= 0;
      nphase = 0; nticks = 0; nwin = 0; nstart = 0;
      m_valid <= 1;
    end else begin
      m_b1 <= bus.btn; m_b2 <= m_b1; m_b3 <= m_b2;
      if (m_start && bus.frame_tick) nstart = 0;
      if (m_phase == 0 && edge_seen) begin
        nphase = 1; nticks = 0; nstart = 1;
      end else if (m_phase == 1 && bus.frame_tick) begin
        if (m_ticks + 1 == 3 * ServeFrames) begin
          nphase = 2; nticks = 0; nstart = 1;
        end else nticks = m_ticks + 1;
      end else if (m_phase == 2) begin
        if (ev) begin
          nticks = 0;
          if (q1 || q2) begin
            nphase = 3; nwin = (q1 ? 1 : 0) + (q2 ? 2 : 0);
          end else nphase = 1;
        end else if (bus.play_state == 2'd0) begin
          nphase = 0; nstart = 0;
        end
      end else if (m_phase == 3 && bus.frame_tick) begin
        if (m_ticks + 1 == OverFrames) begin
          nphase = 0; nticks = 0; nwin = 0;
        end else nticks = m_ticks + 1;
      end
    end
    m_phase <= nphase;
    m_ticks <= nticks;
    m_winner <= nwin;
    m_start <= nstart;
  end

  function automatic int m_countdown();
    return (m_phase == 1) ? 3 - m_ticks / ServeFrames : 0;
  endfunction

  // One compare process, every cycle once reset has been applied.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("phase", int'(bus.phase), m_phase);
      chk("upd_rst", int'(bus.upd_rst), (m_phase == 0) ? 1 : 0);
      chk("upd_start", int'(bus.upd_start), int'(m_start));
      chk("countdown", int'(bus.countdown), m_countdown());
      chk("winner", int'(bus.winner), m_winner);
    end
  end

  // Count vsync samples of start=1 as the updater would see them.
  always @(posedge clk) begin
    if (!rst && bus.upd_start && bus.frame_tick) start_samples <= start_samples + 1;
  end

  // ---------------- Stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(2);
      bus.frame_tick = 1'b1;
      cyc(1);
      bus.frame_tick = 1'b0;
    end
  endtask

  task automatic press();
    bus.btn = 1'b1;
    cyc(4);
    bus.btn = 1'b0;
  endtask

  task automatic wait_phase(input int exp, input int budget);
    int n = 0;
    while (int'(bus.phase) != exp && n < budget) begin
      cyc(1);
      n++;
    end
    chk("wait_phase", int'(bus.phase), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.frame_tick = 1'b0;
    bus.btn        = 1'b0;
    bus.p1_score   = 8'd0;
    bus.p2_score   = 8'd0;
    bus.play_state = 2'd0;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    chk("rst_phase", int'(bus.phase), 0);
    chk("rst_upd_rst", int'(bus.upd_rst), 1);
    chk("rst_upd_start", int'(bus.upd_start), 0);
    chk("rst_countdown", int'(bus.countdown), 0);
    chk("rst_winner", int'(bus.winner), 0);

    // Match 1: start, full countdown.
    press();
    wait_phase(1, 10);
    chk("start_cd3", int'(bus.countdown), 3);
    chk("start_strobe", int'(bus.upd_start), 1);
    chk("start_upd_rst", int'(bus.upd_rst), 0);
    bus.play_state = 2'd1;
    frames(1);
    chk("strobe_done", int'(bus.upd_start), 0);
    chk("strobe_samples1", start_samples, 1);
    bus.p1_score = 8'd6;
    bus.p2_score = 8'd2;
    cyc(1);
    chk("serve_score_ignored", int'(bus.phase), 1);
    frames(3);
    chk("cd_at4", int'(bus.countdown), 2);
    frames(4);
    chk("cd_at8", int'(bus.countdown), 1);
    frames(4);
    chk("rally_phase", int'(bus.phase), 2);
    chk("rally_cd0", int'(bus.countdown), 0);
    chk("rally_strobe", int'(bus.upd_start), 1);
    bus.play_state = 2'd2;
    frames(1);
    chk("strobe_samples2", start_samples, 2);

    // Point scored, no winner: back to SERVE.
    bus.p2_score = 8'd3;
    cyc(1);
    chk("point_phase", int'(bus.phase), 1);
    chk("point_cd3", int'(bus.countdown), 3);
    chk("point_winner", int'(bus.winner), 0);
    chk("point_no_strobe", int'(bus.upd_start), 0);
    frames(11);
    chk("point_still_serve", int'(bus.phase), 1);
    chk("point_samples", start_samples, 2);
    frames(1);
    chk("point_rally", int'(bus.phase), 2);
    chk("point_strobe", int'(bus.upd_start), 1);
    frames(1);

    // Player 1 wins.
    bus.p1_score = 8'd7;
    cyc(1);
    chk("p1_over", int'(bus.phase), 3);
    chk("p1_winner", int'(bus.winner), 1);
    frames(OverFrames - 1);
    chk("over_hold", int'(bus.phase), 3);
    frames(1);
    chk("over_idle", int'(bus.phase), 0);
    chk("over_upd_rst", int'(bus.upd_rst), 1);
    chk("over_winner0", int'(bus.winner), 0);

    // Match 2: draw, buttons ignored during OVER.
    bus.p1_score = 8'd6;
    bus.p2_score = 8'd6;
    cyc(2);
    chk("idle_score_ignored", int'(bus.phase), 0);
    press();
    wait_phase(1, 10);
    frames(3 * ServeFrames);
    chk("m2_rally", int'(bus.phase), 2);
    frames(1);
    bus.p1_score = 8'd7;
    bus.p2_score = 8'd7;
    cyc(1);
    chk("draw_winner", int'(bus.winner), 3);
    press();
    cyc(2);
    chk("over_btn_phase", int'(bus.phase), 3);
    chk("over_btn_start", int'(bus.upd_start), 0);
    frames(OverFrames);
    chk("draw_idle", int'(bus.phase), 0);
    chk("draw_winner0", int'(bus.winner), 0);

    // Match 3: updater reset during RALLY cancels the pending strobe.
    bus.p1_score = 8'd0;
    bus.p2_score = 8'd0;
    cyc(1);
    press();
    wait_phase(1, 10);
    frames(3 * ServeFrames);
    chk("m3_rally", int'(bus.phase), 2);
    chk("m3_strobe", int'(bus.upd_start), 1);
    bus.play_state = 2'd0;
    cyc(1);
    chk("ext_rst_phase", int'(bus.phase), 0);
    chk("ext_rst_start", int'(bus.upd_start), 0);
    chk("ext_rst_upd_rst", int'(bus.upd_rst), 1);
    chk("m3_samples", start_samples, 6);
    bus.play_state = 2'd1;

    // rst during SERVE with a strobe pending.
    press();
    wait_phase(1, 10);
    chk("pre_rst_strobe", int'(bus.upd_start), 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("mid_rst_start", int'(bus.upd_start), 0);
    chk("mid_rst_phase", int'(bus.phase), 0);
    chk("mid_rst_upd_rst", int'(bus.upd_rst), 1);
    frames(2);
    chk("mid_rst_samples", start_samples, 6);
    chk("mid_rst_stays_idle", int'(bus.phase), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/match_sequencer.md
MATCH_SEQUENCER -- requirements
Module: match_sequencer

Interface
REQ-001 Parameter WIN_SCORE, default 7, score at which a match ends.
REQ-002 Parameter SERVE_FRAMES, default 60, frames per countdown step.
REQ-003 Parameter OVER_FRAMES, default 300, frames the result is held in OVER.
REQ-004 clk  in  1  system clock; all logic SHALL be on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 frame_tick  in  1  one-clk pulse per vsync rising edge.
REQ-007 btn  in  1  OR of all controller buttons, asynchronous level.
REQ-008 p1_score, p2_score  in  8 each  scores from the game state updater.
REQ-009 play_state  in  2  updater state: 0 RESET, 1 PLAY_NEXT, 2 PLAY.
REQ-010 upd_rst  out  1  reset request to the updater.
REQ-011 upd_start  out  1  start request to the updater.
REQ-012 phase  out  3  0 IDLE, 1 SERVE, 2 RALLY, 3 OVER.
REQ-013 countdown  out  2  serve digit 3/2/1, else 0.
REQ-014 winner  out  2  0 none, 1 player 1, 2 player 2, 3 draw.

Function
REQ-015 btn SHALL pass a 2-flop synchronizer; btn_edge SHALL be a one-clk pulse on a synchronized 0->1 transition.
REQ-016 A start strobe SHALL assert upd_start on the clk after the trigger and hold it through the cycle carrying the next frame_tick, then deassert, giving exactly one vsync sample of start=1.
REQ-017 IDLE: upd_rst=1, countdown=0. On btn_edge: issue start strobe, load countdown=3, clear frame counter, go to SERVE.
REQ-018 SERVE: upd_rst=0. Each frame_tick increments a 9-bit frame counter. At SERVE_FRAMES-1 the counter clears and countdown decrements. When countdown=1 expires: countdown=0, issue start strobe, go to RALLY.
REQ-019 btn_edge SHALL be ignored in SERVE, RALLY and OVER.
REQ-020 Score registers p1_last/p2_last SHALL be updated every clk. A score event is any clk where p1_score!=p1_last or p2_score!=p2_last.
REQ-021 RALLY, score event, neither score >= WIN_SCORE: go to SERVE with countdown=3 and counter=0. The updater is already in PLAY_NEXT and needs only the end-of-countdown strobe.
REQ-022 RALLY, score event, at least one score >= WIN_SCORE: go to OVER. winner=1 if only p1 qualifies, 2 if only p2, 3 if both in the same clk.
REQ-023 RALLY and play_state==0 (external updater reset) with no score event: go to IDLE and clear any pending strobe.
REQ-024 OVER: winner held. Count OVER_FRAMES frame_ticks. On expiry: winner=0, go to IDLE, where upd_rst=1.
REQ-025 A score event outside RALLY SHALL update p*_last only, with no state change.
REQ-026 A strobe pending when the state changes SHALL complete unaffected; at most one strobe SHALL be pending at a time.
REQ-027 No output SHALL depend combinationally on btn; all outputs SHALL be registered.

Reset
REQ-028 rst SHALL force: phase=IDLE, upd_rst=1, upd_start=0, countdown=0, winner=0, frame counter=0, p1_last=p1_score, p2_last=p2_score, synchronizer flops=0, no pending strobe.
REQ-029 rst asserted mid-strobe or mid-countdown SHALL cancel it on the next clk with no further upd_start.

Verification
REQ-030 Reset, then btn pulse -> upd_start high exactly until the next frame_tick; phase=SERVE, countdown=3.
REQ-031 SERVE with SERVE_FRAMES=4 -> countdown 3->2->1->0 at frame_ticks 4, 8, 12; start strobe at frame 12; phase=RALLY.
REQ-032 RALLY, p2_score 2->3 with WIN_SCORE=7 -> phase=SERVE, countdown=3, winner=0, no strobe until the countdown ends.
REQ-033 RALLY, p1_score 6->7 -> phase=OVER, winner=1; after OVER_FRAMES ticks phase=IDLE, upd_rst=1, winner=0.
REQ-034 Both scores 6->7 in the same clk -> winner=3; btn pulses during OVER have no effect.
REQ-035 rst during SERVE with a strobe pending -> upd_start=0 next clk, phase=IDLE, upd_rst=1.
